// File: rtl/arb_requester.sv
// arb_requester: buffers TDC words in a FIFO and hands them to a shared arbiter
// as framed bursts. A burst is requested when BURST_LEN words are waiting, or
// when a partial burst has sat idle for TIMEOUT cycles. Each burst ends with
// one GAP cycle so the arbiter always sees an o_en falling edge between bursts.
// Optional feature: define ARB_REQ_DROP_CNT_EN to add a saturating 16-bit
// dropped-write counter on o_drop_cnt.
module arb_requester #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_full,
  output logic                  o_ovf,
  output logic                  o_req,
  input  logic                  i_grant,
  output logic                  o_en,
  output logic [DATA_WIDTH-1:0] o_data
`ifdef ARB_REQ_DROP_CNT_EN
  ,
  output logic [15:0]           o_drop_cnt
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] BURST_C  = CNT_W'(BURST_LEN);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_GAP  = 2'd3;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  // Words of the current burst still to be popped after the one in flight.
  logic [CNT_W-1:0]      left_q, left_d;
  logic [CNT_W-1:0]      blen;
  logic                  req_q, req_d;
  logic                  en_q, en_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  ovf_q;
  logic                  push, pop, drop;

  // Acceptance looks only at the pre-pop count, so a full FIFO drops even
  // when a pop happens on the same edge.
  assign push = i_wr_en & (count_q != DEPTH_C);
  assign drop = i_wr_en & ~push;
  assign blen = (count_q > BURST_C) ? BURST_C : count_q;

  // Burst sequencing, idle timeout and output next-state.
  always_comb begin
    state_d = state_q;
    tmo_d   = '0;
    left_d  = left_q;
    pop     = 1'b0;
    en_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && ((count_q >= BURST_C) || (tmo_q == TMO_LAST))) begin
          state_d = ST_REQ;
        end
        if (!push && (count_q != '0) && (count_q < BURST_C)) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_REQ: begin
        if (i_grant) begin
          // First word is popped on the grant edge so it shows up next cycle.
          pop     = 1'b1;
          en_d    = 1'b1;
          left_d  = blen - CNT_W'(1);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // Grant is no longer looked at; the latched length alone ends the burst.
        if (left_q != '0) begin
          pop    = 1'b1;
          en_d   = 1'b1;
          left_d = left_q - CNT_W'(1);
        end else begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    req_d  = (state_d == ST_REQ);
    data_d = pop ? mem[rd_ptr_q] : '0;
  end

  // Occupancy next-state; simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state, pointers and registered outputs; reset flushes the buffer.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tmo_q    <= '0;
      left_q   <= '0;
      req_q    <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      left_q  <= left_d;
      req_q   <= req_d;
      en_q    <= en_d;
      data_q  <= data_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  // Storage array; contents need no reset because the pointers are cleared.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr_q] <= i_wr_data;
    end
  end

`ifdef ARB_REQ_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of dropped writes.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign o_drop_cnt = drop_cnt_q;
`endif

  assign o_full = (count_q == DEPTH_C);
  assign o_ovf  = ovf_q;
  assign o_req  = req_q;
  assign o_en   = en_q;
  assign o_data = data_q;

endmodule

// File: tb/tb_arb_requester.sv
// Bench for arb_requester with default parameters. A queue-based model of the
// buffer and burst protocol is checked against the DUT on every falling edge;
// directed scenarios add literal expectations on burst contents and timing.
module tb_arb_requester;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int TO    = 64;

  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_SEND = 2;
  localparam int PH_GAP  = 3;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          i_wr_en = 1'b0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_grant = 1'b0;
  logic          o_full, o_ovf, o_req, o_en;
  logic [DW-1:0] o_data;
`ifdef ARB_REQ_DROP_CNT_EN
  logic [15:0]   o_drop_cnt;
`endif

  int checks = 0;
  int errors = 0;

  arb_requester #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .BURST_LEN  (BL),
    .TIMEOUT    (TO)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .i_wr_en    (i_wr_en),
    .i_wr_data  (i_wr_data),
    .o_full     (o_full),
    .o_ovf      (o_ovf),
    .o_req      (o_req),
    .i_grant    (i_grant),
    .o_en       (o_en),
    .o_data     (o_data)
`ifdef ARB_REQ_DROP_CNT_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_q holds words waiting, m_burst holds granted words not yet sent.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_burst[$];
  int            m_phase = PH_IDLE;
  int            m_next, m_idle = 0, m_sz, m_n;
  bit            m_accept, m_emit;
  logic          m_en = 1'b0, m_req = 1'b0, m_ovf = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [15:0]   m_drops = '0;

  initial forever begin
    @(posedge sys_clk or posedge sys_rst);
    if (sys_rst) begin
      m_q.delete();
      m_burst.delete();
      m_phase = PH_IDLE;
      m_idle  = 0;
      m_en    = 1'b0;
      m_data  = '0;
      m_req   = 1'b0;
      m_ovf   = 1'b0;
      m_drops = '0;
    end else begin
      m_sz     = m_q.size() + m_burst.size();
      m_accept = i_wr_en && (m_sz < DEPTH);
      m_emit   = 1'b0;
      m_next   = m_phase;
      if (i_wr_en && !m_accept) begin
        m_ovf = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end
      case (m_phase)
        PH_IDLE: begin
          if (m_sz > 0 && (m_sz >= BL || m_idle == TO - 1)) m_next = PH_REQ;
          if (!m_accept && m_sz > 0 && m_sz < BL) m_idle++;
          else m_idle = 0;
        end
        PH_REQ: begin
          m_idle = 0;
          if (i_grant) begin
            m_n = (m_sz < BL) ? m_sz : BL;
            repeat (m_n) m_burst.push_back(m_q.pop_front());
            m_emit = 1'b1;
            m_next = PH_SEND;
          end
        end
        PH_SEND: begin
          m_idle = 0;
          if (m_burst.size() > 0) m_emit = 1'b1;
          else m_next = PH_GAP;
        end
        default: begin
          m_idle = 0;
          m_next = PH_IDLE;
        end
      endcase
      m_en   = m_emit;
      m_data = m_emit ? m_burst.pop_front() : '0;
      if (m_accept) m_q.push_back(i_wr_data);
      m_phase = m_next;
      m_req   = (m_phase == PH_REQ);
    end
  end

  // Per-cycle comparison plus burst capture for the directed checks.
  logic [DW-1:0] got[$];
  int            lens[$];
  int            gaps[$];
  int            cur_len = 0, low_run = 0;
  logic          prev_en = 1'b0;

  initial forever begin
    @(negedge sys_clk);
    check("o_en", o_en, m_en);
    check("o_data", o_data, m_data);
    check("o_req", o_req, m_req);
    check("o_full", o_full, (m_q.size() + m_burst.size()) == DEPTH);
    check("o_ovf", o_ovf, m_ovf);
`ifdef ARB_REQ_DROP_CNT_EN
    check("o_drop_cnt", o_drop_cnt, m_drops);
`endif
    if (o_en) begin
      if (!prev_en) gaps.push_back(low_run);
      got.push_back(o_data);
      cur_len++;
      low_run = 0;
    end else begin
      if (prev_en) lens.push_back(cur_len);
      cur_len = 0;
      low_run++;
    end
    prev_en = o_en;
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    i_wr_en   = 1'b1;
    i_wr_data = d;
    step();
    i_wr_en   = 1'b0;
    i_wr_data = '0;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!o_req && n < maxc) begin
      step();
      n++;
    end
    check("req_wait", o_req, 1'b1);
  endtask

  task automatic wait_en(input int maxc);
    int n = 0;
    while (!o_en && n < maxc) begin
      step();
      n++;
    end
    check("en_wait", o_en, 1'b1);
  endtask

  task automatic clear_capture();
    got.delete();
    lens.delete();
    gaps.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_req", o_req, 1'b0);
    check("rst_en", o_en, 1'b0);
    check("rst_data", o_data, 32'd0);
    check("rst_full", o_full, 1'b0);
    check("rst_ovf", o_ovf, 1'b0);
    sys_rst = 1'b0;
    step();

    // Full burst, grant three cycles after the request rises.
    clear_capture();
    for (int i = 0; i < 8; i++) push_word(i);
    wait_req(10);
    repeat (3) step();
    check("req_held", o_req, 1'b1);
    i_grant = 1'b1;
    step();
    i_grant = 1'b0;
    repeat (12) step();
    check("full_len", got.size(), 8);
    for (int i = 0; i < 8; i++) check("full_word", got[i], i);
    check("full_lens", lens.size(), 1);

    // Partial burst released by the idle timeout.
    clear_capture();
    push_word(32'hA);
    push_word(32'hB);
    push_word(32'hC);
    n = 0;
    while (!o_req && n < 200) begin
      step();
      n++;
    end
    check("tmo_delay", n, 64);
    i_grant = 1'b1;
    step();
    i_grant = 1'b0;
    repeat (8) step();
    check("tmo_len", got.size(), 3);
    check("tmo_w0", got[0], 32'hA);
    check("tmo_w1", got[1], 32'hB);
    check("tmo_w2", got[2], 32'hC);

    // Overflow with no grant, then drain.
    clear_capture();
    for (int i = 0; i < 16; i++) push_word(100 + i);
    check("ovf_full16", o_full, 1'b1);
    check("ovf_before", o_ovf, 1'b0);
    push_word(32'hDEAD);
    check("ovf_full17", o_full, 1'b1);
    check("ovf_set", o_ovf, 1'b1);
`ifdef ARB_REQ_DROP_CNT_EN
    check("drop_cnt", o_drop_cnt, 16'd1);
`endif
    i_grant = 1'b1;
    repeat (40) step();
    i_grant = 1'b0;
    check("ovf_len", got.size(), 16);
    for (int i = 0; i < 16; i++) check("ovf_word", got[i], 100 + i);
    check("ovf_sticky", o_ovf, 1'b1);
    check("ovf_drained", o_full, 1'b0);

    // Back-to-back bursts with grant held high.
    clear_capture();
    i_grant = 1'b1;
    for (int i = 0; i < 16; i++) push_word(i);
    repeat (35) step();
    i_grant = 1'b0;
    check("b2b_bursts", lens.size(), 2);
    check("b2b_len0", lens[0], 8);
    check("b2b_len1", lens[1], 8);
    for (int i = 0; i < 16; i++) check("b2b_word", got[i], i);
    check("b2b_gaps", gaps.size(), 2);
    check("b2b_low", gaps[1] >= 1, 1'b1);

    // Grant dropped on the second word must not shorten the burst.
    clear_capture();
    for (int i = 0; i < 8; i++) push_word(300 + i);
    wait_req(10);
    i_grant = 1'b1;
    wait_en(10);
    step();
    i_grant = 1'b0;
    repeat (12) step();
    check("gdrop_len", got.size(), 8);
    for (int i = 0; i < 8; i++) check("gdrop_word", got[i], 300 + i);

    // Reset on the fourth word: asynchronous clear and discarded contents.
    for (int i = 0; i < 8; i++) push_word(400 + i);
    wait_req(10);
    i_grant = 1'b1;
    wait_en(10);
    repeat (3) step();
    check("mid_en", o_en, 1'b1);
    check("mid_word4", o_data, 403);
    i_grant = 1'b0;
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_en", o_en, 1'b0);
    check("arst_data", o_data, 32'd0);
    check("arst_req", o_req, 1'b0);
    check("arst_ovf", o_ovf, 1'b0);
    step();
    step();
    sys_rst = 1'b0;
    clear_capture();
    repeat (80) step();
    check("post_rst_req", o_req, 1'b0);
    check("post_rst_none", got.size(), 0);
    push_word(32'h55);
    wait_req(100);
    i_grant = 1'b1;
    step();
    i_grant = 1'b0;
    repeat (6) step();
    check("post_rst_len", got.size(), 1);
    check("post_rst_word", got[0], 32'h55);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
